// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   REG_FILE_LEN / RW : architectural register count and index width
//   byp_sel_e         : EX operand bypass select encoding
//   hazard_stage_t    : shadow record of an in-flight register writer
//   stage_match       : does a shadow entry produce a register the ID instruction reads
//   byp_pick          : bypass select for one operand of the instruction entering EX
package hazard_ctrl_pkg;

  localparam int unsigned REG_FILE_LEN = 32;
  localparam int unsigned RW           = $clog2(REG_FILE_LEN);

  typedef logic [RW-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    BYP_RF  = 2'd0,
    BYP_MEM = 2'd1,
    BYP_WB  = 2'd2
  } byp_sel_e;

  typedef enum logic {
    MulIdle = 1'b0,
    MulBusy = 1'b1
  } mul_state_e;

  typedef struct packed {
    logic     valid;
    reg_idx_t dst;
    logic     we;
    logic     is_load;
  } hazard_stage_t;

  // x0 is hardwired, so a write to it never creates a dependency.
  function automatic logic stage_match(hazard_stage_t st, reg_idx_t src, logic use_src);
    return st.valid & st.we & (st.dst == src) & (src != '0) & use_src;
  endfunction

  // Selects are computed one edge early: the EX producer will be in MEM and the
  // MEM producer in WB by the time the consumer executes. EX is checked first so
  // the youngest producer wins.
  function automatic byp_sel_e byp_pick(hazard_stage_t ex, hazard_stage_t mem,
                                        reg_idx_t src, logic use_src);
    if (stage_match(ex, src, use_src) && !ex.is_load) begin
      return BYP_MEM;
    end
    if (stage_match(mem, src, use_src)) begin
      return BYP_WB;
    end
    return BYP_RF;
  endfunction

endpackage

// File: rtl/hazard_mul_seq.sv
// Multi-cycle multiplier sequencer.
//   clk, rst : clock and asynchronous active-high reset
//   start_i  : a multiply is entering EX this cycle
//   busy_o   : multiplier still needs EX (pipeline must hold)
//   done_o   : last busy cycle; the multiply is free to leave EX after the next one
// A multiply occupies EX for MUL_LATENCY cycles; the final one is not busy so the
// following instruction can advance alongside it.
module hazard_mul_seq
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic busy_o,
  output logic done_o
);

  localparam int unsigned     CntW   = $clog2(MUL_LATENCY) + 1;
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  mul_state_e      state_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MulIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        MulIdle: begin
          if (start_i && (MUL_LATENCY > 1)) begin
            state_q <= MulBusy;
            cnt_q   <= CntW'(MUL_LATENCY - 1);
          end
        end
        MulBusy: begin
          cnt_q <= cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            state_q <= MulIdle;
          end
        end
      endcase
    end
  end

  assign busy_o = (state_q == MulBusy);
  assign done_o = busy_o && (cnt_q == CntOne);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core (IF/ID/EX/MEM/WB).
//   clk, rst           : clock and asynchronous active-high reset
//   id_*_i             : decoded fields of the instruction sitting in ID
//   ex_br_taken_i      : branch in EX resolved taken this cycle
//   stall_o            : hold PC and IF/ID
//   ex_bubble_o        : load a NOP into ID/EX
//   mem_bubble_o       : load a NOP into EX/MEM
//   flush_o            : squash IF/ID
//   byp_src1_o/2_o     : registered EX operand selects (0 RF, 1 MEM result, 2 WB data)
//   mul_busy_o         : multiplier occupying EX
// In-flight writers are shadowed for EX and MEM only; a WB-stage producer has
// already written the register file before any consumer in ID reaches EX.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid_i,
  input  logic [RW-1:0] id_src1_i,
  input  logic [RW-1:0] id_src2_i,
  input  logic          id_use1_i,
  input  logic          id_use2_i,
  input  logic [RW-1:0] id_dst_i,
  input  logic          id_we_i,
  input  logic          id_is_load_i,
  input  logic          id_is_mul_i,
  input  logic          ex_br_taken_i,
  output logic          stall_o,
  output logic          ex_bubble_o,
  output logic          mem_bubble_o,
  output logic          flush_o,
  output logic [1:0]    byp_src1_o,
  output logic [1:0]    byp_src2_o,
  output logic          mul_busy_o
);

  hazard_stage_t ex_q, ex_d;
  hazard_stage_t mem_q, mem_d;
  byp_sel_e      byp1_q, byp1_d;
  byp_sel_e      byp2_q, byp2_d;

  logic mul_busy;
  logic mul_done;
  logic mul_start;
  logic load_use;
  logic advance;

  hazard_mul_seq #(
    .MUL_LATENCY(MUL_LATENCY)
  ) u_mul_seq (
    .clk    (clk),
    .rst    (rst),
    .start_i(mul_start),
    .busy_o (mul_busy),
    .done_o (mul_done)
  );

  always_comb begin
    load_use = id_valid_i & ex_q.is_load &
               (stage_match(ex_q, id_src1_i, id_use1_i) |
                stage_match(ex_q, id_src2_i, id_use2_i));

    // A taken branch squashes the dependent instruction, so no stall is needed.
    flush_o      = ex_br_taken_i;
    stall_o      = mul_busy | (load_use & ~ex_br_taken_i);
    ex_bubble_o  = ~mul_busy & (ex_br_taken_i | load_use);
    mem_bubble_o = mul_busy;
    mul_busy_o   = mul_busy;

    advance   = ~stall_o & ~ex_bubble_o;
    mul_start = advance & id_valid_i & id_is_mul_i;
  end

  always_comb begin
    ex_d   = ex_q;
    mem_d  = mem_q;
    byp1_d = byp1_q;
    byp2_d = byp2_q;
    if (mul_busy) begin
      // EX and the selects hold; MEM receives the bubble.
      mem_d = '0;
    end else begin
      mem_d = ex_q;
      if (ex_bubble_o) begin
        ex_d   = '0;
        byp1_d = BYP_RF;
        byp2_d = BYP_RF;
      end else begin
        ex_d.valid   = id_valid_i;
        ex_d.dst     = id_dst_i;
        ex_d.we      = id_we_i;
        ex_d.is_load = id_is_load_i;
        byp1_d       = byp_pick(ex_q, mem_q, id_src1_i, id_use1_i);
        byp2_d       = byp_pick(ex_q, mem_q, id_src2_i, id_use2_i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q   <= '0;
      mem_q  <= '0;
      byp1_q <= BYP_RF;
      byp2_q <= BYP_RF;
    end else begin
      ex_q   <= ex_d;
      mem_q  <= mem_d;
      byp1_q <= byp1_d;
      byp2_q <= byp2_d;
    end
  end

  assign byp_src1_o = byp1_q;
  assign byp_src2_o = byp2_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(ex_br_taken_i && mul_busy))
        else $error("hazard_ctrl: branch resolved while multiplier busy");
      assert (!mul_done || ex_q.valid)
        else $error("hazard_ctrl: multiplier finishing with no instruction in EX");
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int unsigned MulLat = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid_i;
  logic [RW-1:0] id_src1_i, id_src2_i, id_dst_i;
  logic          id_use1_i, id_use2_i, id_we_i, id_is_load_i, id_is_mul_i;
  logic          ex_br_taken_i;
  logic          stall_o, ex_bubble_o, mem_bubble_o, flush_o, mul_busy_o;
  logic [1:0]    byp_src1_o, byp_src2_o;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MUL_LATENCY(MulLat)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid_i   (id_valid_i),
    .id_src1_i    (id_src1_i),
    .id_src2_i    (id_src2_i),
    .id_use1_i    (id_use1_i),
    .id_use2_i    (id_use2_i),
    .id_dst_i     (id_dst_i),
    .id_we_i      (id_we_i),
    .id_is_load_i (id_is_load_i),
    .id_is_mul_i  (id_is_mul_i),
    .ex_br_taken_i(ex_br_taken_i),
    .stall_o      (stall_o),
    .ex_bubble_o  (ex_bubble_o),
    .mem_bubble_o (mem_bubble_o),
    .flush_o      (flush_o),
    .byp_src1_o   (byp_src1_o),
    .byp_src2_o   (byp_src2_o),
    .mul_busy_o   (mul_busy_o)
  );

  // Reference model: the instructions occupying EX and MEM, plus how many EX
  // cycles the multiply in EX still needs.
  typedef struct {
    bit valid;
    int dst;
    bit we;
    bit is_load;
    bit is_mul;
  } ins_t;

  ins_t nop_ins;
  ins_t m_ex, m_mem;
  int   m_mul_left;
  int   m_byp1, m_byp2;

  bit p_hz, p_busy;
  bit e_stall, e_exb, e_memb, e_flush;

  int checks = 0;
  int errors = 0;

  function automatic bit writes_to(ins_t p, int src, bit use_src);
    return use_src && src != 0 && p.valid && p.we && p.dst == src;
  endfunction

  function automatic int pick(ins_t ex, ins_t mem, int src, bit use_src);
    if (writes_to(ex, src, use_src) && !ex.is_load) return 1;
    if (writes_to(mem, src, use_src)) return 2;
    return 0;
  endfunction

  function automatic bit model_busy();
    return m_ex.valid && m_ex.is_mul && m_mul_left > 1;
  endfunction

  function automatic void predict();
    p_hz = id_valid_i && m_ex.is_load &&
           (writes_to(m_ex, int'(id_src1_i), id_use1_i) ||
            writes_to(m_ex, int'(id_src2_i), id_use2_i));
    p_busy  = model_busy();
    e_flush = ex_br_taken_i;
    e_stall = p_busy || (p_hz && !ex_br_taken_i);
    e_exb   = !p_busy && (ex_br_taken_i || p_hz);
    e_memb  = p_busy;
  endfunction

  function automatic void model_reset();
    m_ex       = nop_ins;
    m_mem      = nop_ins;
    m_mul_left = 0;
    m_byp1     = 0;
    m_byp2     = 0;
  endfunction

  function automatic void model_step();
    int   b1, b2;
    ins_t nx;
    predict();
    b1 = pick(m_ex, m_mem, int'(id_src1_i), id_use1_i);
    b2 = pick(m_ex, m_mem, int'(id_src2_i), id_use2_i);
    if (p_busy) begin
      m_mul_left--;
      m_mem = nop_ins;
    end else begin
      m_mem = m_ex;
      if (ex_br_taken_i || p_hz) begin
        m_ex       = nop_ins;
        m_byp1     = 0;
        m_byp2     = 0;
        m_mul_left = 0;
      end else begin
        nx.valid   = id_valid_i;
        nx.dst     = int'(id_dst_i);
        nx.we      = id_we_i;
        nx.is_load = id_is_load_i;
        nx.is_mul  = id_is_mul_i;
        m_ex       = nx;
        m_byp1     = b1;
        m_byp2     = b2;
        m_mul_left = (id_valid_i && id_is_mul_i) ? MulLat : 0;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    assert (got === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d at t=%0t", tag, got, exp, $time);
      end
  endtask

  task automatic check_all();
    predict();
    chk("stall", {1'b0, stall_o}, {1'b0, e_stall});
    chk("ex_bubble", {1'b0, ex_bubble_o}, {1'b0, e_exb});
    chk("mem_bubble", {1'b0, mem_bubble_o}, {1'b0, e_memb});
    chk("flush", {1'b0, flush_o}, {1'b0, e_flush});
    chk("mul_busy", {1'b0, mul_busy_o}, {1'b0, p_busy});
    chk("byp1", byp_src1_o, 2'(m_byp1));
    chk("byp2", byp_src2_o, 2'(m_byp2));
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic tick();
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cycle();
    settle();
    tick();
  endtask

  task automatic drive(input bit v, input int s1, input bit u1, input int s2, input bit u2,
                       input int d, input bit we, input bit ld, input bit mul, input bit br);
    id_valid_i    = v;
    id_src1_i     = RW'(s1);
    id_use1_i     = u1;
    id_src2_i     = RW'(s2);
    id_use2_i     = u2;
    id_dst_i      = RW'(d);
    id_we_i       = we;
    id_is_load_i  = ld;
    id_is_mul_i   = mul;
    ex_br_taken_i = br;
  endtask

  task automatic drive_nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall"}, {1'b0, stall_o}, 2'd0);
    chk({tag, "_exb"}, {1'b0, ex_bubble_o}, 2'd0);
    chk({tag, "_memb"}, {1'b0, mem_bubble_o}, 2'd0);
    chk({tag, "_flush"}, {1'b0, flush_o}, 2'd0);
    chk({tag, "_busy"}, {1'b0, mul_busy_o}, 2'd0);
    chk({tag, "_byp1"}, byp_src1_o, 2'd0);
    chk({tag, "_byp2"}, byp_src2_o, 2'd0);
  endtask

  initial begin
    model_reset();
    drive_nop();
    rst = 1'b1;
    settle();
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ALU producer of x1 followed by a reader of x1: forwarded from MEM, no stall.
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    cycle();
    drive(1, 1, 1, 0, 0, 2, 1, 0, 0, 0);
    settle();
    chk("t1_stall", {1'b0, stall_o}, 2'd0);
    tick();
    drive_nop();
    settle();
    chk("t1_byp1", byp_src1_o, 2'd1);
    tick();

    // Load-use: one stall/bubble cycle, then both operands from WB.
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    cycle();
    drive(1, 5, 1, 5, 1, 6, 1, 0, 0, 0);
    settle();
    chk("t2_stall", {1'b0, stall_o}, 2'd1);
    chk("t2_exb", {1'b0, ex_bubble_o}, 2'd1);
    tick();
    settle();
    chk("t2_stall_gone", {1'b0, stall_o}, 2'd0);
    chk("t2_exb_gone", {1'b0, ex_bubble_o}, 2'd0);
    tick();
    drive_nop();
    settle();
    chk("t2_byp1", byp_src1_o, 2'd2);
    chk("t2_byp2", byp_src2_o, 2'd2);
    tick();

    // Load writing x0 followed by a reader of x0: no hazard, no bypass.
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    cycle();
    drive(1, 0, 1, 0, 1, 3, 1, 0, 0, 0);
    settle();
    chk("t3_stall", {1'b0, stall_o}, 2'd0);
    tick();
    drive_nop();
    settle();
    chk("t3_byp1", byp_src1_o, 2'd0);
    chk("t3_byp2", byp_src2_o, 2'd0);
    tick();

    // Multiply of x7: three busy cycles, then the dependent reader gets MEM bypass.
    drive(1, 0, 0, 0, 0, 7, 1, 0, 1, 0);
    cycle();
    drive(1, 7, 1, 0, 0, 8, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t4_stall", {1'b0, stall_o}, 2'd1);
      chk("t4_memb", {1'b0, mem_bubble_o}, 2'd1);
      chk("t4_busy", {1'b0, mul_busy_o}, 2'd1);
      tick();
    end
    settle();
    chk("t4_stall_end", {1'b0, stall_o}, 2'd0);
    chk("t4_busy_end", {1'b0, mul_busy_o}, 2'd0);
    tick();
    drive_nop();
    settle();
    chk("t4_byp1", byp_src1_o, 2'd1);
    tick();

    // Load-use hazard coinciding with a taken branch: flush wins, no stall.
    drive(1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
    cycle();
    drive(1, 9, 1, 0, 0, 10, 1, 0, 0, 1);
    settle();
    chk("t5_flush", {1'b0, flush_o}, 2'd1);
    chk("t5_exb", {1'b0, ex_bubble_o}, 2'd1);
    chk("t5_stall", {1'b0, stall_o}, 2'd0);
    tick();
    drive_nop();
    cycle();

    // Reset pulsed in the middle of a multiply.
    drive(1, 0, 0, 0, 0, 11, 1, 0, 1, 0);
    cycle();
    drive_nop();
    cycle();
    rst = 1'b1;
    settle();
    check_all_zero("t6");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    settle();
    chk("t6_busy_after", {1'b0, mul_busy_o}, 2'd0);
    tick();

    // Randomized traffic; the ID instruction is held while the pipeline stalls.
    for (int n = 0; n < 1500; n++) begin
      if (!e_stall) begin
        int k;
        k = int'($urandom_range(9));
        id_valid_i   = ($urandom_range(99) < 85);
        id_src1_i    = RW'($urandom_range(7));
        id_src2_i    = RW'($urandom_range(7));
        id_use1_i    = ($urandom_range(3) != 0);
        id_use2_i    = ($urandom_range(1) != 0);
        id_dst_i     = RW'($urandom_range(7));
        id_we_i      = ($urandom_range(9) != 0);
        id_is_load_i = (k < 3);
        id_is_mul_i  = (k == 3);
      end
      ex_br_taken_i = !model_busy() && ($urandom_range(11) == 0);
      cycle();
    end

    drive_nop();
    rst = 1'b1;
    settle();
    check_all_zero("final_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
